// File: rtl/output_collector.sv
// Collects one frame of DEPTH valid-qualified result bytes into a register buffer with a registered read port.
// Optional running signed argmax of the frame when ARGMAX_EN is defined.
module output_collector #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AW-1:0]     rd_addr,
`ifdef ARGMAX_EN
  output logic [DATA_W-1:0] max_val,
  output logic [AW-1:0]     max_idx,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                we;
  logic [AW-1:0]       wr_addr;
  logic                rd_ok;
  logic [DATA_W-1:0]   rd_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign wr_addr = count_q[AW-1:0];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    if (start) begin
      // start wins over any same-cycle in_valid; nothing is written.
      state_d = S_COLLECT;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (in_valid) begin
            we      = 1'b1;
            count_d = count_q + CW'(1);
            if (count_q == CW'(DEPTH - 1)) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (in_valid) ovf_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
  generate
    if (DEPTH == (1 << AW)) begin : g_full_range
      assign rd_ok = 1'b1;
    end else begin : g_partial_range
      assign rd_ok = ({1'b0, rd_addr} < (AW + 1)'(DEPTH));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
    end else begin
      if (we) mem_q[wr_addr] <= in_data;
      rd_q <= rd_ok ? mem_q[rd_addr] : '0;
    end
  end

`ifdef ARGMAX_EN
  logic [DATA_W-1:0] max_val_q;
  logic [AW-1:0]     max_idx_q;

  // Strictly-greater update keeps the lowest index on ties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else if (start) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else if (we && ((count_q == '0) || ($signed(in_data) > $signed(max_val_q)))) begin
      max_val_q <= in_data;
      max_idx_q <= wr_addr;
    end
  end

  assign max_val = max_val_q;
  assign max_idx = max_idx_q;
`endif

  assign rd_data  = rd_q;
  assign count    = count_q;
  assign busy     = (state_q == S_COLLECT);
  assign done     = (state_q == S_DONE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_output_collector.sv
// Directed, table-driven bench for output_collector (DEPTH=4, DATA_W=8).
// Define ARGMAX_EN to also exercise the running-maximum outputs.
module tb_output_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic [2:0] count;
  logic       busy;
  logic       done;
  logic       overflow;
`ifdef ARGMAX_EN
  logic [7:0] max_val;
  logic [1:0] max_idx;
`endif

  int checks = 0;
  int errors = 0;

  output_collector #(.DEPTH(4), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .rd_addr  (rd_addr),
`ifdef ARGMAX_EN
    .max_val  (max_val),
    .max_idx  (max_idx),
`endif
    .rd_data  (rd_data),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog got timeout want finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       st;
    logic       v;
    logic [7:0] d;
    logic [1:0] ra;
    logic [2:0] cnt;
    logic       bsy;
    logic       dn;
    logic       ov;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected values are what the outputs hold just after the edge that consumes the vector.
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'h11, 2'd0, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 8'h22, 2'd0, 3'd2, 1'b1, 1'b0, 1'b0, 8'h11};
    vecs[3]  = '{1'b0, 1'b1, 8'h33, 2'd1, 3'd3, 1'b1, 1'b0, 1'b0, 8'h22};
    vecs[4]  = '{1'b0, 1'b1, 8'h44, 2'd2, 3'd4, 1'b0, 1'b1, 1'b0, 8'h33};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 2'd3, 3'd4, 1'b0, 1'b1, 1'b0, 8'h44};
    vecs[6]  = '{1'b0, 1'b1, 8'h99, 2'd0, 3'd4, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 2'd1, 3'd4, 1'b0, 1'b1, 1'b1, 8'h22};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 2'd2, 3'd4, 1'b0, 1'b1, 1'b1, 8'h33};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 2'd3, 3'd4, 1'b0, 1'b1, 1'b1, 8'h44};
    vecs[10] = '{1'b1, 1'b1, 8'h66, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h11};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h11};
    vecs[12] = '{1'b0, 1'b1, 8'hA1, 2'd0, 3'd1, 1'b1, 1'b0, 1'b0, 8'h11};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 2'd0, 3'd1, 1'b1, 1'b0, 1'b0, 8'hA1};
    vecs[14] = '{1'b0, 1'b1, 8'hA2, 2'd1, 3'd2, 1'b1, 1'b0, 1'b0, 8'h22};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 2'd1, 3'd2, 1'b1, 1'b0, 1'b0, 8'hA2};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 2'd1, 3'd2, 1'b1, 1'b0, 1'b0, 8'hA2};
    vecs[17] = '{1'b0, 1'b1, 8'hA3, 2'd2, 3'd3, 1'b1, 1'b0, 1'b0, 8'h33};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 2'd2, 3'd3, 1'b1, 1'b0, 1'b0, 8'hA3};
    vecs[19] = '{1'b0, 1'b1, 8'hA4, 2'd3, 3'd4, 1'b0, 1'b1, 1'b0, 8'h44};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 2'd3, 3'd4, 1'b0, 1'b1, 1'b0, 8'hA4};

    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rd_addr  = 2'd0;
    #3;
    chk("reset_count", count, 3'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_ovf", overflow, 1'b0);
    chk("reset_rd", rd_data, 8'h00);
`ifdef ARGMAX_EN
    chk("reset_maxv", max_val, 8'h00);
    chk("reset_maxi", max_idx, 2'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();

    for (int i = 0; i < 21; i++) begin
      start    = vecs[i].st;
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      rd_addr  = vecs[i].ra;
      step();
      $display("vec %0d st=%0b v=%0b d=%h ra=%0d -> cnt=%0d busy=%0b done=%0b ovf=%0b rd=%h",
               i, vecs[i].st, vecs[i].v, vecs[i].d, vecs[i].ra, count, busy, done, overflow, rd_data);
      chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].bsy);
      chk($sformatf("v%0d_done", i), done, vecs[i].dn);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ov);
      chk($sformatf("v%0d_rd", i), rd_data, vecs[i].rd);
    end
    start    = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset after two writes of a fresh frame.
    start = 1'b1;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hB1;
    step();
    in_data = 8'hB2;
    step();
    in_valid = 1'b0;
    rd_addr  = 2'd0;
    step();
    chk("pre_rst_count", count, 3'd2);
    chk("pre_rst_rd", rd_data, 8'hB1);
    #2;
    reset = 1'b0;
    #1;
    $display("async reset -> cnt=%0d busy=%0b done=%0b ovf=%0b rd=%h", count, busy, done, overflow, rd_data);
    chk("arst_count", count, 3'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_ovf", overflow, 1'b0);
    chk("arst_rd", rd_data, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      step();
      $display("post reset read addr %0d -> rd=%h busy=%0b", a, rd_data, busy);
      chk($sformatf("arst_mem%0d", a), rd_data, 8'h00);
      chk($sformatf("arst_idle%0d", a), busy, 1'b0);
    end

    // in_valid in IDLE is ignored.
    in_valid = 1'b1;
    in_data  = 8'h55;
    rd_addr  = 2'd0;
    step();
    in_valid = 1'b0;
    chk("idle_count", count, 3'd0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_ovf", overflow, 1'b0);
    step();
    $display("idle write attempt -> cnt=%0d ovf=%0b rd=%h", count, overflow, rd_data);
    chk("idle_mem0", rd_data, 8'h00);

`ifdef ARGMAX_EN
    start = 1'b1;
    step();
    start = 1'b0;
    chk("amax_start_v", max_val, 8'h00);
    in_valid = 1'b1;
    in_data  = 8'h05;
    step();
    chk("amax_first_v", max_val, 8'h05);
    chk("amax_first_i", max_idx, 2'd0);
    in_data = 8'h7F;
    step();
    in_data = 8'h80;
    step();
    in_data = 8'h7F;
    step();
    in_valid = 1'b0;
    $display("argmax frame -> max_val=%h max_idx=%0d done=%0b", max_val, max_idx, done);
    chk("amax_done", done, 1'b1);
    chk("amax_val", max_val, 8'h7F);
    chk("amax_idx", max_idx, 2'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("amax_clr_v", max_val, 8'h00);
    chk("amax_clr_i", max_idx, 2'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
